// File: rtl/divider_32by16_seq.sv
// Sequential restoring divider: a 2*WIDTH-bit unsigned dividend divided by a
// WIDTH-bit unsigned divisor gives a WIDTH-bit quotient and a WIDTH-bit remainder.
// The core produces one quotient bit per clock, and only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   operand handshake; operands are taken when both are high
//   dividend, divisor     unsigned operands
//   out_valid / out_ready result handshake; the result is held until out_ready
//   quotient, remainder   unsigned result
//   div_by_zero           the divisor was zero (quotient is all ones, remainder is dividend low half)
//   overflow              the quotient would not fit in WIDTH bits (same saturated result)
//
// Latency from the accept edge to the first cycle with out_valid high:
//   - WIDTH+1 cycles for a normal divide.
//   - 1 cycle for the error cases.
module divider_32by16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] sh_q;    // remaining dividend bits in, quotient bits out
  logic [WIDTH-1:0] div_q;   // captured divisor
  logic [CntW-1:0]  cnt_q;   // quotient bits still to produce

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] sh_nxt;

  // One restoring step. The partial remainder is always below the divisor.
  // Therefore trial-divisor is below 2^WIDTH whenever trial >= divisor.
  // A set diff[WIDTH] is then exactly the borrow, meaning trial < divisor.
  always_comb begin
    trial   = {rem_q, sh_q[WIDTH-1]};
    diff    = trial - {1'b0, div_q};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    sh_nxt  = {sh_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      sh_q        <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state_q     <= StDone;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // The quotient needs more than WIDTH bits, so it is saturated.
              state_q     <= StDone;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              state_q <= StCalc;
              rem_q   <= dividend[2*WIDTH-1:WIDTH];
              sh_q    <= dividend[WIDTH-1:0];
              div_q   <= divisor;
              cnt_q   <= CntW'(WIDTH);
            end
          end
        end

        StCalc: begin
          rem_q <= rem_nxt;
          sh_q  <= sh_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q     <= StDone;
            out_valid   <= 1'b1;
            quotient    <= sh_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end

        StDone: begin
          // Returning to idle here means no operand is taken on the handshake edge.
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32by16_seq.sv
module tb_divider_32by16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int unsigned n_cmp;
  int unsigned n_err;

  divider_32by16_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and hold them until they are accepted; returns just after the accept edge.
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("result_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_drop", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic dz, input logic ov);
    check({tag, "_q"},  {16'd0, quotient},  {16'd0, q});
    check({tag, "_r"},  {16'd0, remainder}, {16'd0, r});
    check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, dz});
    check({tag, "_ov"}, {31'd0, overflow},    {31'd0, ov});
  endtask

  initial begin
    int          lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rr;
    logic [31:0] rd;

    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_result("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: 100 / 7
    start_op(32'h0000_0064, 16'h0007);
    check("c1_busy", {31'd0, in_ready}, 32'd0);
    wait_result(lat);
    check("c1_latency", lat, 32'd17);
    check_result("c1", 16'h000E, 16'h0002, 1'b0, 1'b0);

    // Case 5: backpressure while new operands toggle on the input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      dividend = 32'h0000_03E8;
      divisor  = 16'h000A;
      @(posedge clk);
      #1;
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_q", {16'd0, quotient},  32'h0000_000E);
      check("bp_r", {16'd0, remainder}, 32'h0000_0002);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_hs_drop",  {31'd0, out_valid}, 32'd0);
    check("bp_hs_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", {31'd0, in_ready}, 32'd0);
    wait_result(lat);
    check("bp_latency", lat, 32'd17);
    check_result("bp", 16'h0064, 16'h0000, 1'b0, 1'b0);
    handshake();

    // Case 2: maximum product
    start_op(32'hFFFE_0001, 16'hFFFF);
    wait_result(lat);
    check_result("c2", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    handshake();

    // Case 3: divide by zero
    start_op(32'h1234_5678, 16'h0000);
    wait_result(lat);
    check("c3_latency", lat, 32'd1);
    check_result("c3", 16'hFFFF, 16'h5678, 1'b1, 1'b0);
    handshake();

    // Case 4: overflow, then the largest quotient that still fits
    start_op(32'h0001_0000, 16'h0001);
    wait_result(lat);
    check("c4_latency", lat, 32'd1);
    check_result("c4a", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    handshake();
    start_op(32'h0000_FFFF, 16'h0001);
    wait_result(lat);
    check_result("c4b", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    handshake();

    // Case 6: reset in the eighth CALC cycle
    start_op(32'h0000_0064, 16'h0007);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("c6_out_valid", {31'd0, out_valid}, 32'd0);
    check("c6_in_ready",  {31'd0, in_ready},  32'd1);
    check_result("c6_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("c6_discarded", {31'd0, out_valid}, 32'd0);
    start_op(32'h0000_0100, 16'h0010);
    wait_result(lat);
    check_result("c6_next", 16'h0010, 16'h0000, 1'b0, 1'b0);
    handshake();

    // Operands built as a*b+r with r<b, so the quotient is a and the remainder is r
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom_range(1, 65535));
      rb = 16'($urandom_range(1, 65535));
      rr = 16'($urandom_range(0, 32'(rb) - 1));
      rd = 32'(ra) * 32'(rb) + 32'(rr);
      start_op(rd, rb);
      wait_result(lat);
      check("rnd_q", {16'd0, quotient},  {16'd0, ra});
      check("rnd_r", {16'd0, remainder}, {16'd0, rr});
      check("rnd_recon", 32'(quotient) * 32'(rb) + 32'(remainder), rd);
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
